simmem_wrsp_releaser: RTL and testbench

Delay-countdown scheduler that sits directly upstream of the write-response bank's release interface. It accepts one (internal identifier, delay) entry per cycle from the delay calculator, counts each entry down independently, and drives the multi-hot release-enable vector that lets the bank emit a stored write response. It retires each slot when the bank reports that address as released.

---
 rtl/simmem_wrsp_releaser.sv | 111 +++++++++++
 tb/tb_simmem_wrsp_releaser.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/simmem_wrsp_releaser.sv
// Delay-countdown scheduler feeding the write-response bank release interface.
// One countdown slot per bank address; a slot is held ELIGIBLE until the bank reports it released.
module simmem_wrsp_releaser #(
  parameter  int Capa   = 8,
  parameter  int DelayW = 8,
  localparam int IidW   = $clog2(Capa),
  localparam int CntW   = $clog2(Capa + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              entry_valid_i,
  output logic              entry_ready_o,
  input  logic [IidW-1:0]   entry_iid_i,
  input  logic [DelayW-1:0] entry_delay_i,
  output logic [Capa-1:0]   release_en_o,
  input  logic [Capa-1:0]   released_addr_onehot_i,
  output logic [CntW-1:0]   num_pending_o
);

  typedef enum logic [1:0] {
    IDLE,
    COUNTING,
    ELIGIBLE
  } slot_state_e;

  slot_state_e       state_q [Capa];
  slot_state_e       state_d [Capa];
  logic [DelayW-1:0] cnt_q   [Capa];
  logic [DelayW-1:0] cnt_d   [Capa];
  logic [CntW-1:0]   pending_q;
  logic [CntW-1:0]   pending_d;
  logic [Capa-1:0]   retire;
  logic              hs;

  // No bypass: a slot retiring this cycle is still reported busy.
  assign entry_ready_o = !rst_i && (state_q[entry_iid_i] == IDLE);
  assign hs            = entry_valid_i && entry_ready_o;

  always_comb begin
    for (int k = 0; k < Capa; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      retire[k]  = 1'b0;
      case (state_q[k])
        IDLE: begin
          if (hs && (entry_iid_i == IidW'(k))) begin
            if (entry_delay_i == '0) begin
              state_d[k] = ELIGIBLE;
            end else begin
              state_d[k] = COUNTING;
              cnt_d[k]   = entry_delay_i;
            end
          end
        end
        COUNTING: begin
          if (cnt_q[k] == DelayW'(1)) begin
            state_d[k] = ELIGIBLE;
            cnt_d[k]   = '0;
          end else begin
            cnt_d[k] = cnt_q[k] - DelayW'(1);
          end
        end
        ELIGIBLE: begin
          // Release pulses for non-eligible slots fall through untouched.
          if (released_addr_onehot_i[k]) begin
            state_d[k] = IDLE;
            retire[k]  = 1'b1;
          end
        end
        default: begin
          state_d[k] = IDLE;
          cnt_d[k]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pending_d = pending_q + CntW'(hs);
    for (int k = 0; k < Capa; k++) begin
      if (retire[k]) begin
        pending_d = pending_d - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < Capa; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
      end
      pending_q <= '0;
    end else begin
      for (int k = 0; k < Capa; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      pending_q <= pending_d;
    end
  end

  always_comb begin
    for (int k = 0; k < Capa; k++) begin
      release_en_o[k] = (state_q[k] == ELIGIBLE);
    end
  end

  assign num_pending_o = pending_q;

endmodule

// File: tb/tb_simmem_wrsp_releaser.sv
// Scoreboard bench for simmem_wrsp_releaser: each accepted entry queues its due release cycle,
// and every rising release-enable bit is matched against that queue.
module tb_simmem_wrsp_releaser;

  localparam int Capa   = 8;
  localparam int DelayW = 8;
  localparam int IidW   = 3;
  localparam int CntW   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              entry_valid;
  logic              entry_ready;
  logic [IidW-1:0]   entry_iid;
  logic [DelayW-1:0] entry_delay;
  logic [Capa-1:0]   release_en;
  logic [Capa-1:0]   released;
  logic [CntW-1:0]   num_pending;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int iid;
    int due;
  } exp_t;
  exp_t sb[$];
  logic [Capa-1:0] prev_en;

  simmem_wrsp_releaser #(.Capa(Capa), .DelayW(DelayW)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .entry_valid_i          (entry_valid),
    .entry_ready_o          (entry_ready),
    .entry_iid_i            (entry_iid),
    .entry_delay_i          (entry_delay),
    .release_en_o           (release_en),
    .released_addr_onehot_i (released),
    .num_pending_o          (num_pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(released)) else $error("multi-hot release 0x%0h", released);
      assert ((released & ~release_en) == '0) else $error("release of non-eligible slot 0x%0h", released);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Match each rising release-enable bit to the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_en = '0;
    end else begin
      for (int k = 0; k < Capa; k++) begin
        if (release_en[k] && !prev_en[k]) begin
          int idx;
          idx = -1;
          for (int j = 0; j < sb.size(); j++) begin
            if (idx < 0 && sb[j].iid == k) idx = j;
          end
          check($sformatf("rise%0d_expected", k), int'(idx >= 0), 1);
          if (idx >= 0) begin
            check($sformatf("rise%0d_cycle", k), cyc, sb[idx].due);
            sb.delete(idx);
          end
        end
      end
      prev_en = release_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int iid, input int d, input bit exp_rdy);
    entry_valid = 1'b1;
    entry_iid   = IidW'(iid);
    entry_delay = DelayW'(d);
    #1;
    check($sformatf("ready_iid%0d", iid), int'(entry_ready), int'(exp_rdy));
    if (exp_rdy) sb.push_back('{iid: iid, due: cyc + d + 1});
    tick();
    entry_valid = 1'b0;
  endtask

  task automatic wait_bit(input int k, input int budget);
    int n;
    n = 0;
    while (!release_en[k] && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("wait_en%0d", k), int'(release_en[k]), 1);
  endtask

  task automatic retire(input int k);
    released = Capa'(1) << k;
    tick();
    released = '0;
  endtask

  task automatic check_all_ready(input bit exp_rdy);
    for (int i = 0; i < Capa; i++) begin
      entry_iid = IidW'(i);
      #1;
      check($sformatf("all_ready_iid%0d", i), int'(entry_ready), int'(exp_rdy));
      tick();
    end
  endtask

  initial begin
    rst         = 1'b1;
    entry_valid = 1'b0;
    entry_iid   = '0;
    entry_delay = '0;
    released    = '0;
    tick();
    tick();
    check("rst_ready", int'(entry_ready), 0);
    check("rst_en", int'(release_en), 0);
    check("rst_pending", int'(num_pending), 0);
    rst = 1'b0;
    #1;

    // Zero delay: eligible the next cycle, held until released in cycle +4.
    offer(3, 0, 1'b1);
    check("d0_en", int'(release_en), 8'h08);
    tick(); tick(); tick();
    check("d0_held", int'(release_en), 8'h08);
    retire(3);
    #1;
    check("d0_en_clr", int'(release_en), 0);
    check("d0_pending", int'(num_pending), 0);

    // Two concurrent countdowns; a re-offer to a busy slot must not disturb it.
    offer(1, 5, 1'b1);
    offer(2, 2, 1'b1);
    check("two_pending", int'(num_pending), 2);
    offer(1, 7, 1'b0);
    wait_bit(2, 20);
    retire(2);
    wait_bit(1, 20);
    retire(1);
    offer(1, 3, 1'b1);
    wait_bit(1, 20);
    retire(1);
    #1;
    check("reuse_pending", int'(num_pending), 0);

    // Fill every slot, then retire slot 0 while slot 5 is re-offered.
    for (int i = 0; i < Capa; i++) offer(i, 10, 1'b1);
    check("full_pending", int'(num_pending), Capa);
    check_all_ready(1'b0);
    wait_bit(0, 40);
    released = 8'h01;
    offer(5, 3, 1'b0);
    released = '0;
    check("full_retire_pending", int'(num_pending), 7);
    entry_iid = 3'd0;
    #1;
    check("slot0_free", int'(entry_ready), 1);
    for (int k = 1; k < Capa; k++) begin
      wait_bit(k, 40);
      retire(k);
    end
    #1;
    check("drain_pending", int'(num_pending), 0);

    // Maximum delay.
    offer(0, 255, 1'b1);
    wait_bit(0, 300);
    retire(0);

    // Reset while four slots count: everything is dropped.
    for (int i = 0; i < 4; i++) offer(i + 2, 20, 1'b1);
    check("pre_rst_pending", int'(num_pending), 4);
    rst = 1'b1;
    sb.delete();
    tick();
    check("mid_rst_en", int'(release_en), 0);
    check("mid_rst_pending", int'(num_pending), 0);
    check("mid_rst_ready", int'(entry_ready), 0);
    rst = 1'b0;
    check_all_ready(1'b1);
    for (int i = 0; i < 30; i++) tick();
    check("post_rst_en", int'(release_en), 0);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
